// File: rtl/timer_axi.sv
// timer_axi: machine timer (64-bit mtime with prescaler, 64-bit mtimecmp) and
// software interrupt bit (msip), exposed as 32-bit words on an AXI4-Lite slave.
// One write and one read may be outstanding at a time, on independent channels.
module timer_axi #(
    parameter int PRESC_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    // write address channel
    input  logic [31:0] s_axi_awaddr,
    input  logic [2:0]  s_axi_awprot,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    // write data channel
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    // write response channel
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    // read address channel
    input  logic [31:0] s_axi_araddr,
    input  logic [2:0]  s_axi_arprot,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    // read data channel
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    // interrupt requests towards the core
    output logic        int_req_timer,
    output logic        int_req_soft
);

    // Word index decoded from addr[4:2]; indices 6 and 7 are holes in the map.
    typedef enum logic [2:0] {
        REG_MTIME_LO    = 3'd0,
        REG_MTIME_HI    = 3'd1,
        REG_MTIMECMP_LO = 3'd2,
        REG_MTIMECMP_HI = 3'd3,
        REG_MSIP        = 3'd4,
        REG_PRESC       = 3'd5,
        REG_HOLE_6      = 3'd6,
        REG_HOLE_7      = 3'd7
    } reg_sel_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // timer state
    logic [63:0]        mtime;
    logic [63:0]        mtimecmp;
    logic               msip;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] pcnt;

    // held write request
    logic               aw_held;
    reg_sel_e           aw_sel;
    logic               w_held;
    logic [31:0]        w_data;
    logic [3:0]         w_strb;

    // combinational helpers
    logic               tick;
    logic               wr_fire;
    logic               wr_mapped;
    logic               aw_hs;
    logic               w_hs;
    logic               ar_hs;
    logic               b_hs;
    logic               r_hs;
    reg_sel_e           ar_sel;
    logic [63:0]        mtime_inc;
    logic [63:0]        mtime_next;
    logic [31:0]        rd_word;
    logic               rd_err;

    // Address bits outside [4:2] and the protection fields carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{s_axi_awaddr[31:5], s_axi_awaddr[1:0],
                           s_axi_araddr[31:5], s_axi_araddr[1:0],
                           s_axi_awprot, s_axi_arprot};

    // Replace the strobed bytes of old_word with those of new_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] result;
        result = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                result[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return result;
    endfunction

    // Each channel accepts a new beat only while nothing of its kind is held
    // and no response is waiting, which keeps the slave single-outstanding.
    assign s_axi_awready = !aw_held && !s_axi_bvalid;
    assign s_axi_wready  = !w_held && !s_axi_bvalid;
    assign s_axi_arready = !s_axi_rvalid;

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign b_hs  = s_axi_bvalid && s_axi_bready;
    assign r_hs  = s_axi_rvalid && s_axi_rready;

    // The register write commits once both halves of the request are held,
    // and only once, because bvalid rises in the same cycle.
    assign wr_fire   = aw_held && w_held && !s_axi_bvalid;
    assign wr_mapped = (aw_sel != REG_HOLE_6) && (aw_sel != REG_HOLE_7);

    assign tick      = (pcnt == presc);
    assign mtime_inc = mtime + 64'(tick);
    assign ar_sel    = reg_sel_e'(s_axi_araddr[4:2]);

    // Next mtime: the tick is applied first so that unwritten bytes keep the
    // incremented value (including any low-to-high carry) and written bytes win.
    always_comb begin
        mtime_next = mtime_inc;
        if (wr_fire && aw_sel == REG_MTIME_LO) begin
            mtime_next[31:0] = merge_bytes(mtime_inc[31:0], w_data, w_strb);
        end
        if (wr_fire && aw_sel == REG_MTIME_HI) begin
            mtime_next[63:32] = merge_bytes(mtime_inc[63:32], w_data, w_strb);
        end
    end

    // Read multiplexer over the current register values; sampling these at the
    // AR edge means a same-cycle write is not visible to the read.
    always_comb begin
        rd_word = 32'd0;
        rd_err  = 1'b0;
        case (ar_sel)
            REG_MTIME_LO:    rd_word = mtime[31:0];
            REG_MTIME_HI:    rd_word = mtime[63:32];
            REG_MTIMECMP_LO: rd_word = mtimecmp[31:0];
            REG_MTIMECMP_HI: rd_word = mtimecmp[63:32];
            REG_MSIP:        rd_word = {31'd0, msip};
            REG_PRESC:       rd_word = 32'(presc);
            default:         rd_err  = 1'b1;
        endcase
    end

    // Write channel: capture AW and W independently, issue the response when the
    // write commits, and release both holds at the B handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            aw_held      <= 1'b0;
            aw_sel       <= REG_MTIME_LO;
            w_held       <= 1'b0;
            w_data       <= 32'd0;
            w_strb       <= 4'd0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_sel  <= reg_sel_e'(s_axi_awaddr[4:2]);
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_data <= s_axi_wdata;
                w_strb <= s_axi_wstrb;
            end
            if (wr_fire) begin
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
            end else if (b_hs) begin
                s_axi_bvalid <= 1'b0;
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
            end
        end
    end

    // Read channel: sample the selected word at the AR handshake and hold it
    // until the master takes it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= 32'd0;
            s_axi_rresp  <= RESP_OKAY;
        end else begin
            if (ar_hs) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_word;
                s_axi_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end else if (r_hs) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

    // Timer registers: free-running mtime behind the prescaler, plus the
    // software-written compare value, msip and prescaler reload.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mtime    <= 64'd0;
            mtimecmp <= '1;
            msip     <= 1'b0;
            presc    <= '0;
            pcnt     <= '0;
        end else begin
            mtime <= mtime_next;

            if (wr_fire && aw_sel == REG_PRESC) begin
                pcnt <= '0;
            end else if (tick) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + PRESC_W'(1);
            end

            if (wr_fire) begin
                case (aw_sel)
                    REG_MTIMECMP_LO: mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0], w_data, w_strb);
                    REG_MTIMECMP_HI: mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], w_data, w_strb);
                    REG_MSIP: begin
                        if (w_strb[0]) begin
                            msip <= w_data[0];
                        end
                    end
                    REG_PRESC:       presc <= PRESC_W'(merge_bytes(32'(presc), w_data, w_strb));
                    default: ;
                endcase
            end
        end
    end

    // Timer interrupt is registered, so it reflects the compare of the values
    // that were current before this edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            int_req_timer <= 1'b0;
        end else begin
            int_req_timer <= (mtime >= mtimecmp);
        end
    end

    assign int_req_soft = msip;

endmodule

// File: tb/tb_timer_axi.sv
// tb_timer_axi: directed and randomized checks of timer_axi against a
// transaction-level model of the register map, prescaler and AXI channels.
module tb_timer_axi;

    localparam int PRESC_W = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] s_axi_awaddr = '0;
    logic [2:0]  s_axi_awprot = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b1;
    logic [31:0] s_axi_araddr = '0;
    logic [2:0]  s_axi_arprot = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b1;
    logic        int_req_timer;
    logic        int_req_soft;

    int total = 0;
    int bad = 0;
    int unsigned cycle = 0;
    bit check_en = 1'b0;

    timer_axi #(.PRESC_W(PRESC_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awprot  (s_axi_awprot),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arprot  (s_axi_arprot),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .int_req_timer (int_req_timer),
        .int_req_soft  (int_req_soft)
    );

    always #5 clk = ~clk;

    // Record one comparison and report it if it does not hold.
    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] m_time, m_cmp;
    logic [31:0] m_pcnt, m_presc;
    bit          m_msip, m_irq;
    bit          m_aw_held, m_w_held, m_bvalid, m_rvalid;
    logic [2:0]  m_aw_idx;
    logic [31:0] m_w_data, m_rdata;
    logic [3:0]  m_w_strb;
    logic [1:0]  m_bresp, m_rresp;
    bit          m_aw_hs, m_w_hs, m_ar_hs, m_b_hs, m_r_hs;

    function automatic logic [31:0] apply_strobe(input logic [31:0] old_word, input logic [31:0] data,
                                                 input logic [3:0] strb);
        logic [31:0] mask;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        return (old_word & ~mask) | (data & mask);
    endfunction

    // {error, word} as seen by a read of map index idx
    function automatic logic [32:0] model_read(input logic [2:0] idx);
        case (idx)
            3'd0: return {1'b0, m_time[31:0]};
            3'd1: return {1'b0, m_time[63:32]};
            3'd2: return {1'b0, m_cmp[31:0]};
            3'd3: return {1'b0, m_cmp[63:32]};
            3'd4: return {1'b0, 31'd0, m_msip};
            3'd5: return {1'b0, m_presc};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    // Model state advances on every edge from the stimulus the bench drives.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_time = 0; m_cmp = '1; m_pcnt = 0; m_presc = 0; m_msip = 0; m_irq = 0;
            m_aw_held = 0; m_w_held = 0; m_bvalid = 0; m_rvalid = 0;
            m_aw_idx = 0; m_w_data = 0; m_w_strb = 0; m_rdata = 0; m_bresp = 0; m_rresp = 0;
            m_aw_hs = 0; m_w_hs = 0; m_ar_hs = 0; m_b_hs = 0; m_r_hs = 0;
        end else begin
            bit tick, fire;
            logic [32:0] rd;
            tick    = (m_pcnt == m_presc);
            fire    = m_aw_held && m_w_held && !m_bvalid;
            m_aw_hs = s_axi_awvalid && !m_aw_held && !m_bvalid;
            m_w_hs  = s_axi_wvalid && !m_w_held && !m_bvalid;
            m_ar_hs = s_axi_arvalid && !m_rvalid;
            m_b_hs  = m_bvalid && s_axi_bready;
            m_r_hs  = m_rvalid && s_axi_rready;

            if (m_ar_hs) begin
                rd = model_read(s_axi_araddr[4:2]);
                m_rdata  = rd[31:0];
                m_rresp  = rd[32] ? 2'b10 : 2'b00;
                m_rvalid = 1;
            end else if (m_r_hs) begin
                m_rvalid = 0;
            end

            m_irq  = (m_time >= m_cmp);
            m_time = m_time + 64'(tick);
            m_pcnt = tick ? 0 : m_pcnt + 1;

            if (fire) begin
                case (m_aw_idx)
                    3'd0: m_time[31:0]  = apply_strobe(m_time[31:0], m_w_data, m_w_strb);
                    3'd1: m_time[63:32] = apply_strobe(m_time[63:32], m_w_data, m_w_strb);
                    3'd2: m_cmp[31:0]   = apply_strobe(m_cmp[31:0], m_w_data, m_w_strb);
                    3'd3: m_cmp[63:32]  = apply_strobe(m_cmp[63:32], m_w_data, m_w_strb);
                    3'd4: if (m_w_strb[0]) m_msip = m_w_data[0];
                    3'd5: begin
                        m_presc = apply_strobe(m_presc, m_w_data, m_w_strb) & ((32'd1 << PRESC_W) - 1);
                        m_pcnt  = 0;
                    end
                    default: ;
                endcase
                m_bvalid = 1;
                m_bresp  = (m_aw_idx >= 3'd6) ? 2'b10 : 2'b00;
            end else if (m_b_hs) begin
                m_bvalid = 0; m_aw_held = 0; m_w_held = 0;
            end
            if (m_aw_hs) begin m_aw_held = 1; m_aw_idx = s_axi_awaddr[4:2]; end
            if (m_w_hs) begin m_w_held = 1; m_w_data = s_axi_wdata; m_w_strb = s_axi_wstrb; end
        end
    end

    // Edge counter since the last reset release.
    always @(posedge clk or negedge reset) begin
        if (!reset) cycle = 0;
        else cycle++;
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (check_en) begin
            check_output("awready", s_axi_awready, !m_aw_held && !m_bvalid);
            check_output("wready", s_axi_wready, !m_w_held && !m_bvalid);
            check_output("arready", s_axi_arready, !m_rvalid);
            check_output("bvalid", s_axi_bvalid, m_bvalid);
            check_output("rvalid", s_axi_rvalid, m_rvalid);
            check_output("int_req_timer", int_req_timer, m_irq);
            check_output("int_req_soft", int_req_soft, m_msip);
            if (m_bvalid) check_output("bresp", s_axi_bresp, m_bresp);
            if (m_rvalid) begin
                check_output("rdata", s_axi_rdata, m_rdata);
                check_output("rresp", s_axi_rresp, m_rresp);
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    // Called just after a rising edge; returns just after the edge of the B handshake.
    task automatic apply_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               input int w_lead, input int b_hold, output logic [1:0] resp);
        bit got = 0, done = 0;
        int hold = b_hold;
        resp = 2'bxx;
        s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1;
        s_axi_bready = (hold == 0);
        for (int i = 0; i < w_lead; i++) begin
            @(posedge clk); #1;
            if (m_w_hs) s_axi_wvalid = 0;
        end
        s_axi_awaddr = addr; s_axi_awvalid = 1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (s_axi_bvalid && !got) begin resp = s_axi_bresp; got = 1; end
            @(posedge clk); #1;
            if (m_aw_hs) s_axi_awvalid = 0;
            if (m_w_hs) s_axi_wvalid = 0;
            if (m_b_hs) done = 1;
            if (got && hold > 0) hold--;
            s_axi_bready = (hold == 0);
        end
        s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_bready = 1;
        if (!done) check_output("write_timeout", 64'd0, 64'd1);
    endtask

    // Raises arvalid immediately; returns just after the edge of the R handshake.
    task automatic apply_read(input logic [31:0] addr, output logic [31:0] data,
                              output logic [1:0] resp, output int unsigned hs_cycle);
        bit got = 0, done = 0;
        data = 'x; resp = 'x; hs_cycle = 0;
        s_axi_araddr = addr; s_axi_arvalid = 1; s_axi_rready = 1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk); #1;
            if (m_ar_hs) begin s_axi_arvalid = 0; hs_cycle = cycle; end
            if (m_r_hs) done = 1;
            else begin
                @(negedge clk);
                if (s_axi_rvalid && !got) begin data = s_axi_rdata; resp = s_axi_rresp; got = 1; end
            end
        end
        s_axi_arvalid = 0;
        if (!done) check_output("read_timeout", 64'd0, 64'd1);
    endtask

    // Random address with the given word index and noise in the ignored bits.
    function automatic logic [31:0] rand_addr(input logic [2:0] idx);
        logic [31:0] a;
        a = $urandom;
        a[4:2] = idx;
        return a;
    endfunction

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin : apply_stimulus
        logic [1:0]  resp;
        logic [31:0] d1, d2;
        int unsigned c1, c2;

        #1 reset = 0;
        #1 check_en = 1;
        #20;
        // reset state
        check_output("rst_awready", s_axi_awready, 1);
        check_output("rst_wready", s_axi_wready, 1);
        check_output("rst_arready", s_axi_arready, 1);
        check_output("rst_bvalid", s_axi_bvalid, 0);
        check_output("rst_rvalid", s_axi_rvalid, 0);
        check_output("rst_bresp", s_axi_bresp, 0);
        check_output("rst_rresp", s_axi_rresp, 0);
        check_output("rst_rdata", s_axi_rdata, 0);
        check_output("rst_irq_timer", int_req_timer, 0);
        check_output("rst_irq_soft", int_req_soft, 0);

        // reset then count: AR handshake at edge 10 samples mtime after 9 edges
        @(negedge clk); reset = 1;
        repeat (9) @(posedge clk);
        #1;
        apply_read(32'h0, d1, resp, c1);
        check_output("count_hs_edge", c1, 10);
        check_output("count_mtime_lo", d1, 9);
        check_output("count_irq", int_req_timer, 0);

        // prescaler: presc=3 gives one tick per 4 edges
        apply_write(32'h14, 32'd3, 4'hF, 0, 0, resp);
        apply_read(32'h0, d1, resp, c1);
        while (cycle < c1 + 39) begin @(posedge clk); #1; end
        apply_read(32'h0, d2, resp, c2);
        check_output("presc_delta", d2 - d1, 10);
        repeat (2) @(posedge clk);
        #1;
        apply_write(32'h14, 32'd3, 4'hF, 0, 0, resp);
        repeat (5) @(posedge clk);
        #1;
        apply_read(32'h0, d1, resp, c1);

        // compare: mtimecmp = {0, 100}
        apply_write(32'h14, 32'd0, 4'hF, 0, 0, resp);
        apply_write(32'h04, 32'd0, 4'hF, 0, 0, resp);
        apply_write(32'h00, 32'd0, 4'hF, 0, 0, resp);
        apply_write(32'h08, 32'd100, 4'hF, 0, 0, resp);
        apply_write(32'h0C, 32'd0, 4'hF, 0, 0, resp);
        check_output("cmp_irq_low", int_req_timer, 0);
        repeat (110) @(posedge clk);
        #1;
        check_output("cmp_irq_high", int_req_timer, 1);
        apply_write(32'h0C, 32'd1, 4'hF, 0, 0, resp);
        repeat (2) @(posedge clk);
        #1;
        check_output("cmp_irq_fall", int_req_timer, 0);

        // carry from the low word into the high word
        apply_write(32'h04, 32'd0, 4'hF, 0, 0, resp);
        apply_write(32'h00, 32'hFFFF_FFFF, 4'hF, 0, 0, resp);
        apply_read(32'h04, d1, resp, c1);
        check_output("carry_mtime_hi", d1, 1);

        // byte strobes: only byte 1 of mtimecmp_lo changes (was 0x64)
        apply_write(32'h08, 32'hAABB_CCDD, 4'b0010, 0, 0, resp);
        apply_read(32'h08, d1, resp, c1);
        check_output("strobe_cmp_lo", d1, 32'h0000_CC64);

        // handshake ordering: W three cycles ahead of AW, bready held low
        apply_write(32'h0C, 32'd5, 4'hF, 3, 5, resp);
        check_output("late_aw_bresp", resp, 2'b00);

        // unmapped word 6
        apply_write(32'h18, 32'h1234_5678, 4'hF, 0, 0, resp);
        check_output("hole_bresp", resp, 2'b10);
        apply_read(32'h18, d1, resp, c1);
        check_output("hole_rdata", d1, 0);
        check_output("hole_rresp", resp, 2'b10);
        apply_read(32'h0C, d1, resp, c1);
        check_output("cmp_hi_after_hole", d1, 5);

        // msip drives the software interrupt
        apply_write(32'h10, 32'd1, 4'hF, 0, 0, resp);
        check_output("msip_soft", int_req_soft, 1);

        // reset while a read response is held
        s_axi_araddr = 32'h10; s_axi_arvalid = 1; s_axi_rready = 0;
        @(posedge clk); #1;
        s_axi_arvalid = 0;
        @(negedge clk);
        check_output("held_rvalid", s_axi_rvalid, 1);
        #2 reset = 0;
        #1;
        check_output("async_rvalid", s_axi_rvalid, 0);
        check_output("async_soft", int_req_soft, 0);
        check_output("async_awready", s_axi_awready, 1);
        check_output("async_arready", s_axi_arready, 1);
        repeat (2) @(negedge clk);
        reset = 1;
        apply_read(32'h0, d1, resp, c1);
        check_output("after_rst_hs_edge", c1, 1);
        check_output("after_rst_mtime", d1, 0);

        // randomized traffic on all channels
        for (int n = 0; n < 3000; n++) begin
            if (!s_axi_awvalid || m_aw_hs) begin
                s_axi_awvalid = ($urandom_range(0, 2) == 0);
                s_axi_awaddr  = rand_addr(3'($urandom_range(0, 7)));
            end
            if (!s_axi_wvalid || m_w_hs) begin
                s_axi_wvalid = ($urandom_range(0, 2) == 0);
                s_axi_wdata  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom;
                s_axi_wstrb  = 4'($urandom);
            end
            if (!s_axi_arvalid || m_ar_hs) begin
                s_axi_arvalid = ($urandom_range(0, 1) == 0);
                s_axi_araddr  = rand_addr(3'($urandom_range(0, 7)));
            end
            s_axi_bready = ($urandom_range(0, 3) != 0);
            s_axi_rready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
        s_axi_bready = 1; s_axi_rready = 1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_en = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
